hht_mem_arbiter: RTL and testbench

Round-robin read arbiter that shares the single-ported HHT operand memory between two burst requesters: the column/data stream (requester 0) and the vector-value stream (requester 1). Each requester presents a base address and beat count. The arbiter grants one burst at a time, generates the sequential read addresses, and steers the returned data back to the winner with a valid strobe and an end-of-burst pulse. It sits between the HHT control sequencer and the operand memory, so the two independent address ports collapse onto one physical port.

---
 rtl/hht_pkg.sv | 16 +
 rtl/hht_rr_pick.sv | 20 ++
 rtl/hht_mem_arbiter.sv | 135 +++++++++++++
 tb/tb_hht_mem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hht_pkg.sv
// Shared types and constants for the HHT operand-memory arbiter.
package hht_pkg;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam logic REQ_COL = 1'b0;
  localparam logic REQ_VEC = 1'b1;

endpackage

// File: rtl/hht_rr_pick.sv
// Two-way round-robin picker: on a tie the requester not served last wins.
module hht_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       winner
);
  import hht_pkg::*;

  always_comb begin
    valid  = |req;
    winner = REQ_COL;
    if (req == 2'b11) begin
      winner = ~last;
    end else if (req[1]) begin
      winner = REQ_VEC;
    end
  end

endmodule

// File: rtl/hht_mem_arbiter.sv
// Round-robin burst read arbiter collapsing the column and vector-value
// streams onto the single-ported HHT operand memory.
module hht_mem_arbiter #(
  parameter int AW = hht_pkg::AW,
  parameter int DW = hht_pkg::DW,
  parameter int LW = hht_pkg::LW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [LW-1:0] len0,
  input  logic [LW-1:0] len1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          done0,
  output logic          done1,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rdata
);
  import hht_pkg::*;

  state_t        state_reg;
  logic [AW-1:0] addr_cnt_reg;
  logic [LW-1:0] beat_cnt_reg;
  logic          owner_reg;
  logic          last_reg;
  logic          gnt0_reg, gnt1_reg;
  logic          mem_rd_reg;
  logic [AW-1:0] mem_addr_reg;
  logic          last_beat_reg;
  logic          rvalid0_reg, rvalid1_reg;
  logic          done0_reg, done1_reg;

  logic          pick_valid;
  logic          pick_winner;
  logic [AW-1:0] sel_addr;
  logic [LW-1:0] sel_len;

  hht_rr_pick u_pick (
    .req    ({req1, req0}),
    .last   (last_reg),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  assign sel_addr = (pick_winner == REQ_VEC) ? addr1 : addr0;
  assign sel_len  = (pick_winner == REQ_VEC) ? len1  : len0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      addr_cnt_reg  <= '0;
      beat_cnt_reg  <= '0;
      owner_reg     <= REQ_COL;
      last_reg      <= REQ_VEC;
      gnt0_reg      <= 1'b0;
      gnt1_reg      <= 1'b0;
      mem_rd_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      last_beat_reg <= 1'b0;
      rvalid0_reg   <= 1'b0;
      rvalid1_reg   <= 1'b0;
      done0_reg     <= 1'b0;
      done1_reg     <= 1'b0;
    end else begin
      gnt0_reg      <= 1'b0;
      gnt1_reg      <= 1'b0;
      mem_rd_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      last_beat_reg <= 1'b0;

      // Return stage: data arrives one cycle after the strobe, tagged by owner.
      rvalid0_reg <= mem_rd_reg    && (owner_reg == REQ_COL);
      rvalid1_reg <= mem_rd_reg    && (owner_reg == REQ_VEC);
      done0_reg   <= last_beat_reg && (owner_reg == REQ_COL);
      done1_reg   <= last_beat_reg && (owner_reg == REQ_VEC);

      case (state_reg)
        IDLE: begin
          if (pick_valid) begin
            gnt0_reg  <= (pick_winner == REQ_COL);
            gnt1_reg  <= (pick_winner == REQ_VEC);
            owner_reg <= pick_winner;
            last_reg  <= pick_winner;
            state_reg <= BURST;
            if (sel_len != '0) begin
              mem_rd_reg    <= 1'b1;
              mem_addr_reg  <= sel_addr;
              addr_cnt_reg  <= sel_addr + AW'(1);
              beat_cnt_reg  <= sel_len - LW'(1);
              last_beat_reg <= (sel_len == LW'(1));
            end else begin
              // Empty burst: no access, but a phantom last beat still yields done.
              addr_cnt_reg  <= sel_addr;
              beat_cnt_reg  <= '0;
              last_beat_reg <= 1'b1;
            end
          end
        end
        BURST: begin
          if (beat_cnt_reg == '0) begin
            state_reg <= IDLE;
          end else begin
            mem_rd_reg    <= 1'b1;
            mem_addr_reg  <= addr_cnt_reg;
            addr_cnt_reg  <= addr_cnt_reg + AW'(1);
            beat_cnt_reg  <= beat_cnt_reg - LW'(1);
            last_beat_reg <= (beat_cnt_reg == LW'(1));
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign gnt0     = gnt0_reg;
  assign gnt1     = gnt1_reg;
  assign mem_rd   = mem_rd_reg;
  assign mem_addr = mem_addr_reg;
  assign rvalid0  = rvalid0_reg;
  assign rvalid1  = rvalid1_reg;
  assign rdata0   = rvalid0_reg ? mem_rdata : '0;
  assign rdata1   = rvalid1_reg ? mem_rdata : '0;
  assign done0    = done0_reg;
  assign done1    = done1_reg;

endmodule

// File: tb/tb_hht_mem_arbiter.sv
// Self-checking bench: transaction-level timing model of the arbiter, directed
// scenarios followed by randomized burst traffic.
module tb_hht_mem_arbiter;

  localparam int NC = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1;
  logic [31:0] addr0, addr1;
  logic [7:0]  len0, len1;
  logic        gnt0, gnt1, rvalid0, rvalid1, done0, done1, mem_rd;
  logic [31:0] rdata0, rdata1, mem_addr, mem_rdata;

  always #5 clk = ~clk;

  hht_mem_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .req1      (req1),
    .addr0     (addr0),
    .addr1     (addr1),
    .len0      (len0),
    .len1      (len1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .rvalid0   (rvalid0),
    .rvalid1   (rvalid1),
    .rdata0    (rdata0),
    .rdata1    (rdata1),
    .done0     (done0),
    .done1     (done1),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata)
  );

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    case (a)
      32'd180: mem_val = 32'd1;
      32'd181: mem_val = 32'd13;
      32'd182: mem_val = 32'd12;
      32'd183: mem_val = 32'd6;
      32'd2:   mem_val = 32'd48;
      32'd3:   mem_val = 32'd81;
      32'd4:   mem_val = 32'd69;
      32'd5:   mem_val = 32'd93;
      default: mem_val = (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endcase
  endfunction

  // Operand memory with one-cycle read latency.
  always @(posedge clk) mem_rdata <= mem_rd ? mem_val(mem_addr) : 32'hDEADBEEF;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    int          start;
  } burst_t;

  burst_t q0[$];
  burst_t q1[$];

  // Expected output for every cycle since the last reset release.
  logic        e_gnt  [0:1][0:NC-1];
  logic        e_rv   [0:1][0:NC-1];
  logic        e_done [0:1][0:NC-1];
  logic [31:0] e_rd   [0:1][0:NC-1];
  logic        e_mrd  [0:NC-1];
  logic [31:0] e_maddr[0:NC-1];

  logic        pend    [0:1];
  logic        granted [0:1];
  int          gcyc    [0:1];
  logic [31:0] cur_addr[0:1];
  logic [7:0]  cur_len [0:1];
  int          first_g [0:1];
  int          free_cyc;
  int          m_last;
  int          cyc;
  bit          rand_mode;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 2; i++) begin
      for (int c = 0; c < NC; c++) begin
        e_gnt[i][c]  = 1'b0;
        e_rv[i][c]   = 1'b0;
        e_done[i][c] = 1'b0;
        e_rd[i][c]   = 32'd0;
      end
      pend[i]     = 1'b0;
      granted[i]  = 1'b0;
      gcyc[i]     = 0;
      cur_addr[i] = 32'd0;
      cur_len[i]  = 8'd0;
      first_g[i]  = -1;
    end
    for (int c = 0; c < NC; c++) begin
      e_mrd[c]   = 1'b0;
      e_maddr[c] = 32'd0;
    end
    q0.delete();
    q1.delete();
    free_cyc = 0;
    m_last   = 1;
  endtask

  function automatic burst_t rand_burst(input int start);
    burst_t b;
    if ($urandom_range(0, 7) == 0) b.addr = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
    else                           b.addr = 32'($urandom_range(0, 255));
    if ($urandom_range(0, 5) == 0) b.len = 8'($urandom_range(6, 12));
    else                            b.len = 8'($urandom_range(0, 5));
    b.start = start;
    return b;
  endfunction

  task automatic load(input int i, input burst_t b);
    pend[i]     = 1'b1;
    granted[i]  = 1'b0;
    cur_addr[i] = b.addr;
    cur_len[i]  = b.len;
  endtask

  task automatic step();
    int     w;
    int     len_i;
    int     span;
    burst_t b;
    chk("gnt0",     32'(gnt0),     32'(e_gnt[0][cyc]));
    chk("gnt1",     32'(gnt1),     32'(e_gnt[1][cyc]));
    chk("mem_rd",   32'(mem_rd),   32'(e_mrd[cyc]));
    chk("mem_addr", mem_addr,      e_maddr[cyc]);
    chk("rvalid0",  32'(rvalid0),  32'(e_rv[0][cyc]));
    chk("rvalid1",  32'(rvalid1),  32'(e_rv[1][cyc]));
    chk("rdata0",   rdata0,        e_rd[0][cyc]);
    chk("rdata1",   rdata1,        e_rd[1][cyc]);
    chk("done0",    32'(done0),    32'(e_done[0][cyc]));
    chk("done1",    32'(done1),    32'(e_done[1][cyc]));
    if (gnt0 === 1'b1 && first_g[0] < 0) first_g[0] = cyc;
    if (gnt1 === 1'b1 && first_g[1] < 0) first_g[1] = cyc;

    if (rand_mode) begin
      if (!pend[0] && q0.size() == 0 && $urandom_range(0, 2) == 0) q0.push_back(rand_burst(cyc));
      if (!pend[1] && q1.size() == 0 && $urandom_range(0, 2) == 0) q1.push_back(rand_burst(cyc));
    end
    // A requester drops its request in the cycle after it saw its grant.
    for (int i = 0; i < 2; i++)
      if (pend[i] && granted[i] && gcyc[i] < cyc) pend[i] = 1'b0;
    if (!pend[0] && q0.size() > 0 && q0[0].start <= cyc) begin b = q0.pop_front(); load(0, b); end
    if (!pend[1] && q1.size() > 0 && q1[0].start <= cyc) begin b = q1.pop_front(); load(1, b); end

    req0  = pend[0];
    addr0 = pend[0] ? cur_addr[0] : 32'd0;
    len0  = pend[0] ? cur_len[0]  : 8'd0;
    req1  = pend[1];
    addr1 = pend[1] ? cur_addr[1] : 32'd0;
    len1  = pend[1] ? cur_len[1]  : 8'd0;

    if (cyc >= free_cyc && (pend[0] || pend[1])) begin
      if (pend[0] && pend[1]) w = 1 - m_last;
      else                    w = pend[1] ? 1 : 0;
      len_i = int'(cur_len[w]);
      e_gnt[w][cyc+1] = 1'b1;
      for (int k = 0; k < len_i; k++) begin
        e_mrd[cyc+1+k]     = 1'b1;
        e_maddr[cyc+1+k]   = cur_addr[w] + 32'(k);
        e_rv[w][cyc+2+k]   = 1'b1;
        e_rd[w][cyc+2+k]   = mem_val(cur_addr[w] + 32'(k));
      end
      span = (len_i == 0) ? 1 : len_i;
      e_done[w][cyc+span+1] = 1'b1;
      free_cyc   = cyc + span + 1;
      m_last     = w;
      granted[w] = 1'b1;
      gcyc[w]    = cyc + 1;
    end

    @(negedge clk);
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_gnt0",     32'(gnt0),    32'd0);
    chk("rst_gnt1",     32'(gnt1),    32'd0);
    chk("rst_mem_rd",   32'(mem_rd),  32'd0);
    chk("rst_mem_addr", mem_addr,     32'd0);
    chk("rst_rvalid0",  32'(rvalid0), 32'd0);
    chk("rst_rvalid1",  32'(rvalid1), 32'd0);
    chk("rst_rdata0",   rdata0,       32'd0);
    chk("rst_rdata1",   rdata1,       32'd0);
    chk("rst_done0",    32'(done0),   32'd0);
    chk("rst_done1",    32'(done1),   32'd0);
    req0 = 1'b0; req1 = 1'b0;
    addr0 = 32'd0; addr1 = 32'd0; len0 = 8'd0; len1 = 8'd0;
    repeat (2) @(negedge clk);
    clear_model();
    cyc   = 0;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    addr0 = 32'd0; addr1 = 32'd0; len0 = 8'd0; len1 = 8'd0;
    rand_mode = 1'b0;
    cyc = 0;
    clear_model();
    @(negedge clk);

    // Single requester, 4-beat burst
    do_reset();
    q0.push_back('{32'd180, 8'd4, 0});
    run(10);
    chk("s1_gnt0_cycle", 32'(first_g[0]), 32'd1);

    // Tie after reset: requester 0 first, requester 1 in cycle 6
    do_reset();
    q0.push_back('{32'd180, 8'd4, 0});
    q1.push_back('{32'd2,   8'd2, 0});
    run(12);
    chk("s2_gnt1_cycle", 32'(first_g[1]), 32'd6);

    // Continuous single-beat requests alternate
    do_reset();
    for (int i = 0; i < 4; i++) begin
      q0.push_back('{32'd180 + 32'(i), 8'd1, 0});
      q1.push_back('{32'd2   + 32'(i), 8'd1, 0});
    end
    run(20);

    // Zero-length burst, then a burst from requester 0 right after
    do_reset();
    q1.push_back('{32'd100, 8'd0, 0});
    q0.push_back('{32'd180, 8'd2, 2});
    run(10);
    chk("s4_gnt0_cycle", 32'(first_g[0]), 32'd3);

    // Address wrap
    do_reset();
    q0.push_back('{32'hFFFF_FFFE, 8'd3, 0});
    run(8);

    // Reset in the middle of a burst, then a tie goes to requester 0
    do_reset();
    q0.push_back('{32'd180, 8'd4, 0});
    run(3);
    do_reset();
    q0.push_back('{32'd2,   8'd2, 0});
    q1.push_back('{32'd180, 8'd1, 0});
    run(10);
    chk("s6_gnt0_cycle", 32'(first_g[0]), 32'd1);

    // Randomized traffic, then drain
    do_reset();
    rand_mode = 1'b1;
    run(500);
    rand_mode = 1'b0;
    run(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
